// File: rtl/sa_input_stage.sv
// -----------------------------------------------------------------------------
// sa_input_stage
//   Input-port stage of a switch allocator. It picks one local virtual channel
//   (VC) per cycle by round-robin and forwards that VC's output-port request to
//   the main allocator. The main-allocator grant is steered back to the winning
//   VC in the same cycle.
//
//   Optional feature (macro SA_PKT_LOCK_EN):
//     When this macro is defined, a packet lock is built. After a non-tail flit
//     of VC w is granted, the stage locks onto w until w's tail flit is granted.
//     When the macro is undefined, arbitration is per flit, tail_i is ignored and
//     locked_o is tied low.
//
// Parameters
//   N : router port count (width of each per-VC request slice)
//   V : VCs per input port, 2..16
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_i      in   V*N  per-VC port requests, VC k in bits [k*N +: N]
//   tail_i     in   V    head-of-queue flit of VC k is a tail flit
//   grant_i    in   1    main-allocator grant for port_req_o (same cycle)
//   port_req_o out  N    request slice of the local winner
//   vc_sel_o   out  V    one-hot local winner, zero when there is no winner
//   vc_grant_o out  V*N  grant returned to the winning VC's slice
//   locked_o   out  1    stage is locked onto one VC's packet
// -----------------------------------------------------------------------------
module sa_input_stage #(
  parameter int N = 5,
  parameter int V = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [V*N-1:0] req_i,
  input  logic [V-1:0]   tail_i,
  input  logic           grant_i,
  output logic [N-1:0]   port_req_o,
  output logic [V-1:0]   vc_sel_o,
  output logic [V*N-1:0] vc_grant_o,
  output logic           locked_o
);

  localparam int PW      = (V > 1) ? $clog2(V) : 1;
  localparam bit IS_POW2 = ((V & (V - 1)) == 0);

  logic [PW-1:0] r_ptr;
  logic [V-1:0]  w_valid;
  logic [V-1:0]  w_elig;
  logic [V-1:0]  w_lock_mask;
  logic          w_locked;
  logic          w_found;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_take;

  // A VC requests when any bit of its slice is set. A slice with several bits
  // set is passed through unchanged.
  always_comb begin
    w_valid = '0;
    for (int k = 0; k < V; k++) begin
      w_valid[k] = |req_i[k*N +: N];
    end
  end

`ifdef SA_PKT_LOCK_EN
  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_lock_vc;
  logic [PW-1:0] w_lock_vc_nxt;

  // Lock state and locked VC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lock_vc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_vc <= w_lock_vc_nxt;
    end
  end

  // Lock transitions. A grant with no winner is ignored. This includes the
  // case where the locked VC is currently empty.
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_vc_nxt = r_lock_vc;
    case (r_state)
      S_IDLE: begin
        if (w_take && !tail_i[w_win]) begin
          w_state_nxt   = S_LOCKED;
          w_lock_vc_nxt = w_win;
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (w_take && tail_i[r_lock_vc]) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_LOCKED;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_lock_vc_nxt = '0;
      end
    endcase
  end

  assign w_locked    = (r_state == S_LOCKED);
  assign w_lock_mask = V'(1) << r_lock_vc;
`else
  // Per-flit arbitration: tail flags carry no meaning for this build.
  logic w_unused_tail;
  assign w_unused_tail = ^tail_i;
  assign w_locked      = 1'b0;
  assign w_lock_mask   = '0;
`endif

  // When locked, only the locked VC may compete.
  always_comb begin
    if (w_locked) begin
      w_elig = w_valid & w_lock_mask;
    end else begin
      w_elig = w_valid;
    end
  end

  // Round-robin search upward from r_ptr, wrapping V-1 -> 0. The first
  // eligible VC found wins.
  always_comb begin
    logic [PW:0] v_sum;
    w_found = 1'b0;
    w_win   = '0;
    v_sum   = '0;
    for (int i = 0; i < V; i++) begin
      v_sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (v_sum >= (PW+1)'(V)) begin
        v_sum = v_sum - (PW+1)'(V);
      end else begin
        v_sum = v_sum;
      end
      if (!w_found && w_elig[v_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_sum[PW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_take = grant_i && w_found;

  // Pointer successor: natural wrap for power-of-two V, explicit wrap otherwise.
  generate
    if (IS_POW2) begin : g_wrap_pow2
      assign w_ptr_nxt = w_win + PW'(1);
    end else begin : g_wrap_cmp
      assign w_ptr_nxt = (w_win == PW'(V - 1)) ? '0 : (w_win + PW'(1));
    end
  endgenerate

  // Round-robin pointer. When a locked packet releases, w_win equals the
  // locked VC, so this same update gives lock_vc + 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_take) begin
      r_ptr <= w_ptr_nxt;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Zero-latency request forwarding and grant steering.
  always_comb begin
    vc_sel_o   = '0;
    port_req_o = '0;
    vc_grant_o = '0;
    if (w_found) begin
      vc_sel_o[w_win] = 1'b1;
      port_req_o      = req_i[w_win*N +: N];
      if (grant_i) begin
        vc_grant_o[w_win*N +: N] = req_i[w_win*N +: N];
      end else begin
        vc_grant_o = '0;
      end
    end else begin
      vc_sel_o = '0;
    end
  end

  assign locked_o = w_locked;

endmodule

// File: tb/tb_sa_input_stage.sv
// -----------------------------------------------------------------------------
// tb_sa_input_stage
//   Self-checking bench for sa_input_stage (N=5, V=4). A behavioural model
//   holds the pointer and lock status as plain integers. It predicts the winner
//   with modular arithmetic. Directed scenarios are followed by randomized
//   traffic. Define SA_PKT_LOCK_EN for both the bench and the RTL to exercise
//   the packet lock.
// -----------------------------------------------------------------------------
module tb_sa_input_stage;

  localparam int N = 5;
  localparam int V = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [V*N-1:0] req;
  logic [V-1:0]   tail;
  logic           grant;
  logic [N-1:0]   port_req_o;
  logic [V-1:0]   vc_sel_o;
  logic [V*N-1:0] vc_grant_o;
  logic           locked_o;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_ptr     = 0;
  bit m_locked  = 1'b0;
  int m_lock_vc = 0;

  localparam logic [V*N-1:0] ALL_P2 = {V{5'b00100}};

  sa_input_stage #(.N(N), .V(V)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .tail_i     (tail),
    .grant_i    (grant),
    .port_req_o (port_req_o),
    .vc_sel_o   (vc_sel_o),
    .vc_grant_o (vc_grant_o),
    .locked_o   (locked_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner();
    int w;
    w = -1;
    if (m_locked) begin
      if (req[m_lock_vc*N +: N] != '0) w = m_lock_vc;
    end else begin
      for (int i = 0; i < V; i++) begin
        int k;
        k = (m_ptr + i) % V;
        if (w < 0 && req[k*N +: N] != '0) w = k;
      end
    end
    return w;
  endfunction

  task automatic drive(input logic [V*N-1:0] r, input logic [V-1:0] t, input logic g);
    req   = r;
    tail  = t;
    grant = g;
    #1;
  endtask

  // Compare all outputs with the model at the falling edge, then advance the model.
  task automatic step(input string tag);
    int          w;
    logic [31:0] e_sel, e_preq, e_vg;
    @(negedge clk);
    w      = model_winner();
    e_sel  = '0;
    e_preq = '0;
    e_vg   = '0;
    if (w >= 0) begin
      e_sel  = 32'd1 << w;
      e_preq = 32'(req[w*N +: N]);
      if (grant) e_vg = e_preq << (w*N);
    end
    check_eq({tag, ".sel"},    32'(vc_sel_o),   e_sel);
    check_eq({tag, ".preq"},   32'(port_req_o), e_preq);
    check_eq({tag, ".vgrant"}, 32'(vc_grant_o), e_vg);
    check_eq({tag, ".locked"}, 32'(locked_o),   32'(m_locked));
    @(posedge clk);
    if (grant && w >= 0) begin
      m_ptr = (w + 1) % V;
`ifdef SA_PKT_LOCK_EN
      if (!m_locked && !tail[w]) begin
        m_locked  = 1'b1;
        m_lock_vc = w;
      end else if (m_locked && tail[m_lock_vc]) begin
        m_locked = 1'b0;
      end
`endif
    end
    #1;
  endtask

  logic [V-1:0] rr_seq [5];

  initial begin
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst   = 1'b1;
    req   = '0;
    tail  = '0;
    grant = 1'b0;
    #1;
    check_eq("rst.locked", 32'(locked_o), 32'd0);
    check_eq("rst.sel_idle", 32'(vc_sel_o), 32'd0);
    req   = ALL_P2;
    grant = 1'b1;
    #1;
    check_eq("rst.sel_all", 32'(vc_sel_o), 32'b0001);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // round robin, every VC requesting port 2, granted every cycle
    drive(ALL_P2, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_eq("rr.seq", 32'(vc_sel_o), 32'(rr_seq[i]));
      step("rr");
    end

    // sparse request: move ptr to 2, then VC1+VC3
    drive(20'(5'b00100) << N, 4'hF, 1'b1);
    step("sp.prep");
    drive((20'(5'b00100) << N) | (20'(5'b01000) << (3*N)), 4'hF, 1'b1);
    check_eq("sp.sel_vc3", 32'(vc_sel_o), 32'b1000);
    step("sp1");
    drive((20'(5'b00100) << N) | (20'(5'b01000) << (3*N)), 4'hF, 1'b0);
    check_eq("sp.sel_vc1", 32'(vc_sel_o), 32'b0010);
    step("sp2");

    // grant with nobody requesting is ignored
    drive('0, 4'hF, 1'b1);
    check_eq("idle.vgrant", 32'(vc_grant_o), 32'd0);
    step("idle");
    drive(ALL_P2, 4'hF, 1'b0);
    check_eq("idle.ptr_held", 32'(vc_sel_o), 32'b0001);
    step("idle2");

    // single-flit packet on VC3
    drive(20'(5'b00001) << (3*N), 4'hF, 1'b1);
    step("sf");
    check_eq("sf.locked", 32'(locked_o), 32'd0);
    drive(ALL_P2, 4'hF, 1'b0);
    check_eq("sf.ptr0", 32'(vc_sel_o), 32'b0001);
    step("sf2");

`ifdef SA_PKT_LOCK_EN
    // lock on VC0 head, VC0 drops out, then tail releases
    drive(ALL_P2, 4'h0, 1'b1);
    step("lk.head");
    check_eq("lk.locked", 32'(locked_o), 32'd1);
    drive(ALL_P2, 4'h0, 1'b1);
    check_eq("lk.only_vc0", 32'(vc_sel_o), 32'b0001);
    step("lk.body");
    for (int i = 0; i < 2; i++) begin
      drive(ALL_P2 & ~20'h1F, 4'h0, 1'b1);
      check_eq("lk.gap_preq", 32'(port_req_o), 32'd0);
      step("lk.gap");
    end
    drive(ALL_P2, 4'h1, 1'b1);
    step("lk.tail");
    drive(ALL_P2, 4'h0, 1'b0);
    check_eq("lk.released", 32'(locked_o), 32'd0);
    check_eq("lk.next_vc1", 32'(vc_sel_o), 32'b0010);
    step("lk.after");
    // lock on VC2, then reset in the middle of the cycle
    drive(20'(5'b00100) << (2*N), 4'h0, 1'b1);
    step("lk2.head");
    drive(ALL_P2, 4'h0, 1'b0);
    check_eq("lk2.locked", 32'(locked_o), 32'd1);
    check_eq("lk2.sel", 32'(vc_sel_o), 32'b0100);
`else
    drive(ALL_P2, 4'hF, 1'b1);
    step("pre_rst");
    drive(ALL_P2, 4'hF, 1'b0);
    check_eq("pre_rst.sel", 32'(vc_sel_o), 32'b0010);
`endif
    rst = 1'b1;
    #1;
    check_eq("arst.locked", 32'(locked_o), 32'd0);
    check_eq("arst.sel", 32'(vc_sel_o), 32'b0001);
    m_ptr    = 0;
    m_locked = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(ALL_P2, 4'hF, 1'b0);
    check_eq("arst.after", 32'(vc_sel_o), 32'b0001);
    step("arst2");

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic [V*N-1:0] r;
      r = '0;
      for (int k = 0; k < V; k++) begin
        if ($urandom_range(0, 99) < 60) r[k*N +: N] = 5'($urandom_range(1, 31));
      end
      drive(r, 4'($urandom), ($urandom_range(0, 99) < 70));
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_input_stage.md
SA_INPUT_STAGE -- requirements
Module: sa_input_stage

Interface
REQ-001 SHALL have parameter N, default 5, router port count (width of every port-request vector).
REQ-002 SHALL have parameter V, default 4, VCs per input port; legal range 2..16.
REQ-003 SHALL have port clk input 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst input 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req_i input V*N: per-VC output-port request, VC k in bits [k*N +: N]; VC k is valid when its slice is non-zero.
REQ-006 SHALL have port tail_i input V: bit k high when VC k's head-of-queue flit is a tail flit.
REQ-007 SHALL have port port_req_o output N: request slice of the local winner sent to the main allocator.
REQ-008 SHALL have port vc_sel_o output V: one-hot local winner; all-zero when there is no winner.
REQ-009 SHALL have port grant_i input 1: main-allocator grant for port_req_o, same cycle.
REQ-010 SHALL have port vc_grant_o output V*N: grant to VC k in slice k, equal to port_req_o when VC k is winner and grant_i=1, else zero.
REQ-011 SHALL have port locked_o output 1: high while in state LOCKED.

Function
REQ-012 Local arbitration SHALL be round-robin over valid VCs, searching upward from pointer ptr (log2 V bits), wrapping from V-1 to 0.
REQ-013 vc_sel_o, port_req_o and vc_grant_o SHALL be combinational from inputs and state: zero-cycle request and grant latency.
REQ-014 ptr SHALL load (winner+1) mod V on a clock edge with grant_i=1 and a winner; otherwise it SHALL hold.
REQ-015 grant_i=1 with no valid VC SHALL be ignored: no state change, vc_grant_o zero.
REQ-016 A VC slice with more than one bit high SHALL be passed through unmodified; the block does not check it.
REQ-017 State machine states SHALL be IDLE and LOCKED, with register lock_vc. These states are used only when SA_PKT_LOCK_EN is defined.
REQ-018 IDLE to LOCKED SHALL occur on grant_i=1 with winner w and tail_i[w]=0; lock_vc<=w.
REQ-019 In LOCKED, the winner SHALL be lock_vc only; other VCs are masked.
REQ-020 In LOCKED, if VC lock_vc is not valid, outputs SHALL be zero and the state SHALL stay LOCKED.
REQ-021 LOCKED to IDLE SHALL occur on grant_i=1 with tail_i[lock_vc]=1; ptr<=lock_vc+1 on that same edge.
REQ-022 Grant of a head-and-tail flit (tail_i=1) in IDLE SHALL leave the state IDLE.
REQ-023 When V is a power of two, the pointer SHALL wrap without extra logic; otherwise it SHALL compare explicitly and wrap V-1 to 0.

Reset
REQ-024 While rst=1, ptr SHALL be 0, the state SHALL be IDLE, and lock_vc SHALL be 0, taking effect asynchronously; locked_o SHALL be 0.
REQ-025 Combinational outputs during reset SHALL reflect the reset state (ptr=0, IDLE).
REQ-026 Reset asserted while LOCKED SHALL abandon the lock; after release, arbitration SHALL restart from VC0.

Configuration
REQ-027 Macro SA_PKT_LOCK_EN: when defined, the packet lock of REQ-017..REQ-022 SHALL be built.
REQ-028 When SA_PKT_LOCK_EN is undefined, arbitration SHALL be per-flit round-robin, tail_i SHALL be ignored, and locked_o SHALL be tied 0.

Verification
REQ-029 Round robin, no lock (N=5, V=4): all VCs request port 2 (slice 5'b00100), grant_i=1 every cycle after reset -> vc_sel_o cycles 0001,0010,0100,1000,0001.
REQ-030 Sparse request: VC1 and VC3 valid, ptr=2 -> vc_sel_o=1000; after grant, ptr=0 -> vc_sel_o=0010.
REQ-031 Idle grant: no requests, grant_i=1 -> vc_grant_o=0, and ptr unchanged on the following request.
REQ-032 Lock (SA_PKT_LOCK_EN): VC0 head granted with tail_i[0]=0, VC1-3 valid -> locked_o=1 and VC0 only selected. VC0 then drops its request for 2 cycles -> port_req_o=0. Tail granted -> IDLE, and the next winner is VC1.
REQ-033 Reset while LOCKED on VC2 -> locked_o=0 immediately; after release, with all VCs valid, vc_sel_o=0001.
REQ-034 Single-flit packet: tail_i[3]=1 granted -> state stays IDLE, ptr=0.
